// File: rtl/cam_filter_pkg.sv
// Shared constants and types for the 3x3 camera filter.
//   - Filter mode encodings.
//   - Default frame dimensions.
//   - RGB444 channel slice positions.
//   - Pixel and window types.
package cam_filter_pkg;

  localparam logic [1:0] MODE_BYPASS  = 2'd0;
  localparam logic [1:0] MODE_GAUSS   = 2'd1;
  localparam logic [1:0] MODE_SOBEL   = 2'd2;
  localparam logic [1:0] MODE_SHARPEN = 2'd3;

  localparam int unsigned DEF_WIDTH  = 640;
  localparam int unsigned DEF_HEIGHT = 480;

  // {R[3:0], G[3:0], B[3:0]}
  localparam int unsigned CH_W     = 4;
  localparam int unsigned CH_R_LSB = 8;
  localparam int unsigned CH_G_LSB = 4;
  localparam int unsigned CH_B_LSB = 0;

  typedef logic [11:0] rgb_t;
  // Window element index = row * 3 + col; row 0 is the oldest line, col 0 the oldest column.
  typedef rgb_t [8:0] win_t;

endpackage

// File: rtl/line_buffer.sv
// One line of pixel history: simple dual-port RAM with registered read.
//   clk     : system clock
//   rd_en   : read enable; rd_data updates one cycle later
//   rd_addr : read column
//   rd_data : read pixel (holds when rd_en is low)
//   wr_en   : write enable
//   wr_addr : write column
//   wr_data : write pixel
// A read and write to the same address in one cycle returns the old contents.
module line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [11:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [11:0]   wr_data
);

  logic [11:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cam_filter3x3.sv
// Streaming 3x3 spatial filter (bypass / Gaussian / Sobel / sharpen) on an RGB444 raster stream.
//   clk, rst              : system clock, synchronous active-high reset
//   mode                  : requested mode, latched on each frame-start strobe
//   in_valid/row/col/rgb  : raster-ordered input pixel strobe
//   out_valid/addr/rgb    : filtered pixel centred one row and one column behind the input,
//                           with framebuffer address row*WIDTH+col; three cycles after input
//   active_mode           : mode of the current frame
module cam_filter3x3
  import cam_filter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        in_valid,
  input  logic [8:0]  in_row,
  input  logic [9:0]  in_col,
  input  logic [11:0] in_rgb,
  output logic        out_valid,
  output logic [18:0] out_addr,
  output logic [11:0] out_rgb,
  output logic [1:0]  active_mode
);

  localparam int unsigned AW       = $clog2(WIDTH);
  localparam logic [8:0]  LAST_ROW = 9'(HEIGHT - 1);
  localparam logic [9:0]  LAST_COL = 10'(WIDTH - 1);

  // ---------------------------------------------------------------- kernel arithmetic
  function automatic logic [3:0] chan(rgb_t p, int unsigned lsb);
    return p[lsb +: CH_W];
  endfunction

  function automatic logic [3:0] gauss_ch(win_t w, int unsigned lsb);
    logic [7:0] s;
    s = 8'(chan(w[0], lsb)) + 8'(chan(w[2], lsb)) + 8'(chan(w[6], lsb)) + 8'(chan(w[8], lsb))
      + {3'b0, chan(w[1], lsb), 1'b0} + {3'b0, chan(w[3], lsb), 1'b0}
      + {3'b0, chan(w[5], lsb), 1'b0} + {3'b0, chan(w[7], lsb), 1'b0}
      + {2'b0, chan(w[4], lsb), 2'b0};
    return s[7:4];
  endfunction

  function automatic logic [3:0] gray(rgb_t p);
    logic [5:0] s;
    s = 6'(chan(p, CH_R_LSB)) + {1'b0, chan(p, CH_G_LSB), 1'b0} + 6'(chan(p, CH_B_LSB));
    return s[5:2];
  endfunction

  function automatic logic [3:0] sobel_e(win_t w);
    logic [8:0][3:0] g;
    logic [6:0] gx, gy, ax, ay;
    logic [7:0] mag, sh;
    for (int i = 0; i < 9; i++) g[i] = gray(w[i]);
    // Modulo-128 arithmetic yields the 7-bit two's complement response.
    gx = 7'(g[2]) + 7'({g[5], 1'b0}) + 7'(g[8]) - 7'(g[0]) - 7'({g[3], 1'b0}) - 7'(g[6]);
    gy = 7'(g[6]) + 7'({g[7], 1'b0}) + 7'(g[8]) - 7'(g[0]) - 7'({g[1], 1'b0}) - 7'(g[2]);
    ax = gx[6] ? 7'(-gx) : gx;
    ay = gy[6] ? 7'(-gy) : gy;
    mag = {1'b0, ax} + {1'b0, ay};
    sh = mag >> 3;
    return (sh > 8'd15) ? 4'hF : sh[3:0];
  endfunction

  function automatic logic [3:0] sharpen_ch(win_t w, int unsigned lsb);
    logic [3:0] c;
    logic [7:0] v;
    c = chan(w[4], lsb);
    v = {2'b0, c, 2'b0} + {4'b0, c}
      - {4'b0, chan(w[1], lsb)} - {4'b0, chan(w[7], lsb)}
      - {4'b0, chan(w[3], lsb)} - {4'b0, chan(w[5], lsb)};
    if (v[7]) return 4'h0;
    if (v[6:4] != 3'd0) return 4'hF;
    return v[3:0];
  endfunction

  function automatic rgb_t filt(win_t w, logic [1:0] m, logic border);
    rgb_t r;
    r = w[4];
    if (!border) begin
      case (m)
        MODE_GAUSS: r = {gauss_ch(w, CH_R_LSB), gauss_ch(w, CH_G_LSB), gauss_ch(w, CH_B_LSB)};
        MODE_SOBEL: r = {3{sobel_e(w)}};
        MODE_SHARPEN: r = {sharpen_ch(w, CH_R_LSB), sharpen_ch(w, CH_G_LSB),
                           sharpen_ch(w, CH_B_LSB)};
        default: r = w[4];
      endcase
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- stage 1: input + LB read
  logic        armed_q;
  logic        frame_start, emit;
  logic        s1_valid_q, s1_emit_q, s1_border_q;
  logic [8:0]  s1_orow_q;
  logic [9:0]  s1_ocol_q, s1_col_q;
  logic [11:0] s1_rgb_q;
  logic [1:0]  s1_mode_q;
  logic [11:0] lb0_rdata, lb1_rdata;

  assign frame_start = in_valid && (in_row == 9'd0) && (in_col == 10'd0);
  assign emit = in_valid && armed_q && (in_row != 9'd0) && (in_col != 10'd0)
             && (in_row <= LAST_ROW) && (in_col <= LAST_COL);

  line_buffer #(.DEPTH(WIDTH)) u_lb0 (
    .clk     (clk),
    .rd_en   (in_valid),
    .rd_addr (in_col[AW-1:0]),
    .rd_data (lb0_rdata),
    .wr_en   (s1_valid_q),
    .wr_addr (s1_col_q[AW-1:0]),
    .wr_data (s1_rgb_q)
  );

  // lb1 takes the row lb0 is about to overwrite.
  line_buffer #(.DEPTH(WIDTH)) u_lb1 (
    .clk     (clk),
    .rd_en   (in_valid),
    .rd_addr (in_col[AW-1:0]),
    .rd_data (lb1_rdata),
    .wr_en   (s1_valid_q),
    .wr_addr (s1_col_q[AW-1:0]),
    .wr_data (lb0_rdata)
  );

  // ---------------------------------------------------------------- stage 2: window
  win_t       win_q;
  logic       s2_emit_q, s2_border_q;
  logic [8:0] s2_row_q;
  logic [9:0] s2_col_q;
  logic [1:0] s2_mode_q;

  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_col_q    <= in_col;
      s1_rgb_q    <= in_rgb;
      s1_orow_q   <= in_row - 9'd1;
      s1_ocol_q   <= in_col - 10'd1;
      s1_border_q <= (in_row == 9'd1) || (in_col == 10'd1);
      // Carry the mode with the pixel so the previous frame's tail keeps its own mode.
      s1_mode_q   <= frame_start ? mode : active_mode;
    end
    if (s1_valid_q) begin
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= lb1_rdata;
      win_q[3] <= win_q[4];
      win_q[4] <= win_q[5];
      win_q[5] <= lb0_rdata;
      win_q[6] <= win_q[7];
      win_q[7] <= win_q[8];
      win_q[8] <= s1_rgb_q;
      s2_row_q    <= s1_orow_q;
      s2_col_q    <= s1_ocol_q;
      s2_border_q <= s1_border_q;
      s2_mode_q   <= s1_mode_q;
    end
  end

  // ---------------------------------------------------------------- control + output register
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q     <= 1'b0;
      active_mode <= MODE_BYPASS;
      s1_valid_q  <= 1'b0;
      s1_emit_q   <= 1'b0;
      s2_emit_q   <= 1'b0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_rgb     <= '0;
    end else begin
      if (frame_start) begin
        armed_q     <= 1'b1;
        active_mode <= mode;
      end
      s1_valid_q <= in_valid;
      s1_emit_q  <= emit;
      s2_emit_q  <= s1_emit_q;
      out_valid  <= s2_emit_q;
      if (s2_emit_q) begin
        out_rgb  <= filt(win_q, s2_mode_q, s2_border_q);
        // Constant multiply; for WIDTH = 640 this is (row << 9) + (row << 7).
        out_addr <= 19'(s2_row_q) * 19'(WIDTH) + 19'(s2_col_q);
      end
    end
  end

endmodule

// File: tb/tb_cam_filter3x3.sv
module tb_cam_filter3x3;

  localparam int W = 16;
  localparam int H = 12;
  localparam int NPIX = W * H;

  localparam int K_RAMP  = 0;
  localparam int K_IMP   = 1;
  localparam int K_FLAT  = 2;
  localparam int K_EDGE  = 3;
  localparam int K_SHARP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic [8:0]  in_row;
  logic [9:0]  in_col;
  logic [11:0] in_rgb;
  logic        out_valid;
  logic [18:0] out_addr;
  logic [11:0] out_rgb;
  logic [1:0]  active_mode;

  cam_filter3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .in_valid    (in_valid),
    .in_row      (in_row),
    .in_col      (in_col),
    .in_rgb      (in_rgb),
    .out_valid   (out_valid),
    .out_addr    (out_addr),
    .out_rgb     (out_rgb),
    .active_mode (active_mode)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int out_cnt, stray, lat_in_cyc, lat_out_cyc, rst_base, ref_cnt;
  bit          cap_hit [NPIX];
  logic [11:0] cap_rgb [NPIX];
  logic [30:0] seq_cur [256];
  logic [30:0] seq_ref [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor, sampled mid-cycle.
  initial begin
    int a;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        a = int'(out_addr);
        if (out_cnt < 256) seq_cur[out_cnt] = {out_addr, out_rgb};
        if (a < NPIX) begin
          cap_hit[a] = 1'b1;
          cap_rgb[a] = out_rgb;
        end else stray++;
        if (a == W + 1) lat_out_cyc = cyc;
        out_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] pix(int kind, int r, int c);
    case (kind)
      K_RAMP:  return 12'(c);
      K_IMP:   return (r == 5 && c == 5) ? 12'hFFF : 12'h000;
      K_FLAT:  return 12'h888;
      K_EDGE:  return (c >= W / 2) ? 12'hFFF : 12'h000;
      default: return (r == 5 && c == 5) ? 12'h888 : 12'h444;
    endcase
  endfunction

  // Hand-derived results for the directed frames (impulses sit at (5,5)).
  function automatic logic [11:0] exp_px(int kind, int m, int r, int c);
    int d;
    d = ((r > 5) ? r - 5 : 5 - r) + ((c > 5) ? c - 5 : 5 - c);
    if (m == 0 || r == 0 || c == 0) return pix(kind, r, c);
    case (m)
      1: begin
        if (kind == K_FLAT) return 12'h888;
        if (d == 0) return 12'h333;
        if (d == 1 && (r == 5 || c == 5)) return 12'h111;
        return 12'h000;
      end
      2: return (c == W / 2 - 1 || c == W / 2) ? 12'h777 : 12'h000;
      default: begin
        if (d == 0) return 12'hFFF;
        if (d == 1 && (r == 5 || c == 5)) return 12'h000;
        return 12'h444;
      end
    endcase
  endfunction

  task automatic clear_cap();
    for (int i = 0; i < NPIX; i++) begin
      cap_hit[i] = 1'b0;
      cap_rgb[i] = 12'h000;
    end
    for (int i = 0; i < 256; i++) seq_cur[i] = '0;
    out_cnt = 0;
    stray = 0;
    lat_in_cyc = -100;
    lat_out_cyc = -1;
  endtask

  task automatic drive_px(input int r, input int c, input logic [11:0] p, input int gap);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_row = 9'(r);
    in_col = 10'(c);
    in_rgb = p;
    if (r == 2 && c == 2) lat_in_cyc = cyc;
    for (int g = 1; g < gap; g++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic reset_probe();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rst_base = out_cnt;
    check("midrst_addr", 32'(out_addr), 32'd0);
    check("midrst_rgb", 32'(out_rgb), 32'd0);
    check("midrst_mode", 32'(active_mode), 32'd0);
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic send_frame(input int kind, input int gap, input logic [1:0] m,
                            input int chg_row, input logic [1:0] m2, input int rst_row);
    mode = m;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == chg_row && c == 0) mode = m2;
        if (r == rst_row && c == 0) reset_probe();
        drive_px(r, c, pix(kind, r, c), gap);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int kind, input int m);
    int bad;
    bad = 0;
    for (int r = 0; r < H - 1; r++) begin
      for (int c = 0; c < W - 1; c++) begin
        if (!cap_hit[r * W + c] || cap_rgb[r * W + c] !== exp_px(kind, m, r, c)) bad++;
      end
    end
    check({tag, "_count"}, 32'(out_cnt), 32'((H - 1) * (W - 1)));
    check({tag, "_badpix"}, 32'(bad), 32'd0);
    check({tag, "_stray"}, 32'(stray), 32'd0);
  endtask

  task automatic check_px(input string tag, input int r, input int c, input logic [11:0] e);
    check(tag, cap_hit[r * W + c] ? 32'(cap_rgb[r * W + c]) : 32'hFFFF_FFFF, 32'(e));
  endtask

  initial begin
    int diff;
    rst = 1'b1;
    in_valid = 1'b0;
    in_row = '0;
    in_col = '0;
    in_rgb = '0;
    mode = 2'd0;
    clear_cap();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_addr", 32'(out_addr), 32'd0);
    check("reset_rgb", 32'(out_rgb), 32'd0);
    check("reset_mode", 32'(active_mode), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Bypass ramp, back-to-back strobes.
    clear_cap();
    send_frame(K_RAMP, 1, 2'd0, -1, 2'd0, -1);
    check_frame("ramp1", K_RAMP, 0);
    check("ramp1_latency", 32'(lat_out_cyc - lat_in_cyc), 32'd3);
    for (int i = 0; i < 256; i++) seq_ref[i] = seq_cur[i];
    ref_cnt = out_cnt;

    // Same frame, strobe every other cycle: identical output sequence.
    clear_cap();
    send_frame(K_RAMP, 2, 2'd0, -1, 2'd0, -1);
    check_frame("ramp2", K_RAMP, 0);
    check("ramp2_latency", 32'(lat_out_cyc - lat_in_cyc), 32'd3);
    diff = 0;
    for (int i = 0; i < 256; i++) if (seq_ref[i] !== seq_cur[i]) diff++;
    check("ramp2_seq_diff", 32'(diff), 32'd0);
    check("ramp2_seq_len", 32'(out_cnt), 32'(ref_cnt));

    // Gaussian impulse and flat field.
    clear_cap();
    send_frame(K_IMP, 1, 2'd1, -1, 2'd1, -1);
    check("gauss_mode", 32'(active_mode), 32'd1);
    check_px("gauss_centre", 5, 5, 12'h333);
    check_px("gauss_north", 4, 5, 12'h111);
    check_px("gauss_diag", 4, 4, 12'h000);
    check_frame("gauss_imp", K_IMP, 1);
    clear_cap();
    send_frame(K_FLAT, 1, 2'd1, -1, 2'd1, -1);
    check_frame("gauss_flat", K_FLAT, 1);

    // Sobel vertical edge between columns W/2-1 and W/2.
    clear_cap();
    send_frame(K_EDGE, 1, 2'd2, -1, 2'd2, -1);
    check("sobel_mode", 32'(active_mode), 32'd2);
    check_px("sobel_left", 5, W / 2 - 1, 12'h777);
    check_px("sobel_right", 5, W / 2, 12'h777);
    check_px("sobel_row0_pass", 0, W / 2, 12'hFFF);
    check_frame("sobel", K_EDGE, 2);

    // Sharpen impulse with clamping.
    clear_cap();
    send_frame(K_SHARP, 1, 2'd3, -1, 2'd3, -1);
    check_px("sharp_centre", 5, 5, 12'hFFF);
    check_px("sharp_west", 5, 4, 12'h000);
    check_frame("sharp", K_SHARP, 3);

    // Mode change mid-frame waits for the next frame.
    clear_cap();
    send_frame(K_IMP, 1, 2'd0, 6, 2'd1, -1);
    check("modechg_active", 32'(active_mode), 32'd0);
    check_px("modechg_centre", 5, 5, 12'hFFF);
    check_frame("modechg_bypass", K_IMP, 0);
    clear_cap();
    send_frame(K_IMP, 1, 2'd1, -1, 2'd1, -1);
    check("modechg_next_active", 32'(active_mode), 32'd1);
    check_frame("modechg_next_gauss", K_IMP, 1);

    // Reset mid-frame: silence until the next frame start, then exact output.
    clear_cap();
    send_frame(K_RAMP, 1, 2'd2, -1, 2'd2, 6);
    check("midrst_silent", 32'(out_cnt), 32'(rst_base));
    check("midrst_mode_after", 32'(active_mode), 32'd0);
    clear_cap();
    send_frame(K_IMP, 1, 2'd1, -1, 2'd1, -1);
    check_frame("midrst_next", K_IMP, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_filter3x3.md
# cam_filter3x3

Streaming 3×3 spatial filter between the camera capture stage and the framebuffer write port. Consumes the raster-ordered RGB444 pixel stream (row, col, valid) produced by capture and emits filtered pixels with a precomputed framebuffer write address. Supports four modes: bypass, Gaussian blur, Sobel edge magnitude and sharpen. Runs in the system clock domain and holds two line buffers of history.

## Interface
Parameters:
- `WIDTH`, 640: active pixels per line.
- `HEIGHT`, 480: active lines per frame.

Ports:
- `clk`, in, 1: system clock. One clock; all logic is on `clk`.
- `rst`, in, 1: reset, synchronous and active-high.
- `mode`, in, 2: requested filter mode. 0 = bypass, 1 = Gaussian, 2 = Sobel, 3 = sharpen.
- `in_valid`, in, 1: one-cycle strobe marking an input pixel. At most one per cycle; gaps between strobes are arbitrary.
- `in_row`, in, 9: row of the input pixel.
- `in_col`, in, 10: column of the input pixel.
- `in_rgb`, in, 12: input pixel as {R[3:0], G[3:0], B[3:0]}.
- `out_valid`, out, 1: one-cycle strobe marking an output pixel.
- `out_addr`, out, 19: framebuffer address of the output pixel, out_row·WIDTH + out_col.
- `out_rgb`, out, 12: filtered pixel, same channel packing as `in_rgb`.
- `active_mode`, out, 2: mode latched for the current frame.

## Operation
- **Input order:** pixels arrive in raster order. A frame starts when `in_valid` is high with `in_row` = 0 and `in_col` = 0 (frame-start strobe).
- **Mode latching:** `mode` is sampled into `active_mode` only on a frame-start strobe. A mode change mid-frame takes effect at the next frame.
- **Armed flag:** set on the first frame-start strobe after reset. While clear, input is written to the line buffers but `out_valid` stays 0.
- **Line buffers:**
  - lb0 holds row r−1 and lb1 holds row r−2.
  - On a valid pixel at column c: read lb0[c] and lb1[c]; one cycle later write `in_rgb` to lb0[c] and the old lb0[c] to lb1[c].
  - Reads are read-before-write.
- **Window:** each valid pixel shifts a new column {lb1[c], lb0[c], in} into the 3×3 window.
- **Emission rule:**
  - An input at (r, c) with r ≥ 1 and c ≥ 1 emits the output pixel centred at (r−1, c−1).
  - Inputs with r = 0 or c = 0 emit nothing.
  - Output row HEIGHT−1 and output column WIDTH−1 are never emitted; the framebuffer keeps its prior contents there.
- **Border pass-through:** if the output centre has row 0 or column 0, `out_rgb` is the unfiltered centre pixel, in every mode.
- **Arithmetic** (per 4-bit channel unless noted; results truncate):
  - Bypass: output = centre pixel.
  - Gaussian: kernel 1 2 1 / 2 4 2 / 1 2 1. The 8-bit sum is shifted right by 4.
  - Sobel:
    - Gray per pixel g = (R + 2G + B) >> 2, 4 bits.
    - Gx and Gy are the standard Sobel responses, 7-bit signed.
    - Edge e = (|Gx| + |Gy|) >> 3, saturated to 15.
    - Output is {e, e, e}.
  - Sharpen: 5·centre − N − S − E − W in signed 8 bits, clamped to 0..15.
- **Mid-frame reset:** clears the pipeline, the armed flag and `active_mode` (to 0). Line buffer contents are not cleared. No output is produced until the next frame-start strobe.

## Timing
- Reset values: `out_valid` = 0, `out_addr` = 0, `out_rgb` = 0, `active_mode` = 0.
- Fixed latency: an `in_valid` at cycle t that emits a pixel produces `out_valid` at t+3.
- Pipeline stages:
  1. Input register and line buffer read.
  2. Window shift.
  3. Kernel arithmetic.
  4. Output register.
- The pipeline is never stalled; throughput is one pixel per cycle. Back-to-back `in_valid` must be supported.
- `out_addr` is computed as (row << 9) + (row << 7) + col for WIDTH = 640, and is registered in the same stage as `out_rgb`.
- A frame-start strobe coinciding with `rst` is ignored; reset wins.

## Structure
- **Package `cam_filter_pkg`:**
  - Mode constants MODE_BYPASS, MODE_GAUSS, MODE_SOBEL, MODE_SHARPEN.
  - Default frame dimensions.
  - RGB444 channel slice constants.
- **Sub-module `line_buffer`:** simple dual-port RAM, WIDTH×12 bits, 1-cycle read latency, inferred as block RAM. Instantiated twice.
- Kernel arithmetic lives in the top module as functions.

## Test plan
- **Bypass, address ramp:** mode 0, ramp frame with in_rgb = col[11:0], strobes every cycle.
  - Required: exactly 479·639 outputs, with out_rgb = input at (r, c) and out_addr = r·640 + c.
  - Repeat with strobes every 2 cycles; the output sequence must be identical.
- **Gaussian impulse:** mode 1, frame of 0x000 with a single 0xFFF at (10,10).
  - Required: out(10,10) = 0x333, out(9,10) = 0x111, out(9,9) = 0x000.
  - Flat 0x888 frame: every output = 0x888.
- **Sobel vertical edge:** mode 2, cols < 320 = 0x000, cols ≥ 320 = 0xFFF.
  - Required: cols 319 and 320 = 0x777 for rows 1..478; all other outputs 0x000.
  - Column 0 and row 0 pass through unfiltered.
- **Sharpen impulse:** mode 3, 0x888 impulse on a 0x444 background.
  - Required: centre = 0xFFF (clamp), its 4 neighbours = 0x000.
- **Mid-frame mode change:** change mode 0→1 at row 200.
  - Required: the rest of the frame stays bypass, `active_mode` stays 0; the next frame is Gaussian.
- **Mid-frame reset:** assert `rst` at row 200.
  - Required: `out_valid` = 0 on the following cycle and stays 0 until the next frame start.
  - That next frame must match the golden model exactly.
